regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-read-port register file with an integrated pending-write scoreboard for the pipelined CPU core.
- Replaces the fixed 32x32, 2-read, negedge-write register bank. All state is updated on the rising edge; same-cycle write-to-read bypass hides the write latency.
- The scoreboard tracks registers with an outstanding writeback, so issue logic can stall on RAW hazards without a separate hazard unit.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of architectural registers (power of two, >= 2).
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, 1, if 1, register 0 reads as 0, ignores writes and is never busy.
- BYPASS, 1, if 1, a same-cycle write is forwarded to matching read ports.

Ports:
- clk, input, 1, system clock; rising edge active.
- rst, input, 1, asynchronous active-high reset.
- rd_addr, input, NUM_RD*AW, packed read addresses; port i is bits [i*AW +: AW], where AW = $clog2(DEPTH).
- rd_data, output, NUM_RD*DATA_W, packed combinational read data; port i is bits [i*DATA_W +: DATA_W].
- rd_busy, output, NUM_RD, per-port flag: the addressed register has a pending write.
- wr_en, input, 1, write strobe.
- wr_addr, input, AW, write address.
- wr_data, input, DATA_W, write data.
- iss_en, input, 1, issue strobe: marks iss_addr as pending.
- iss_addr, input, AW, destination register of the issuing instruction.
- flush, input, 1, synchronous clear of all busy bits; register contents are unaffected.
- busy_vec, output, DEPTH, raw scoreboard state.

Behaviour:
- Reset (async, rst=1): all registers are 0 and busy_vec is all 0. Consequently rd_data is 0 and rd_busy is 0 for every port. Reset asserted mid-operation aborts any write in progress that cycle.
- Write: on a rising clk edge with wr_en=1, reg[wr_addr] <= wr_data. Latency is 1 cycle to storage. If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read: combinational, rd_data[i] = reg[rd_addr[i]].
  - ZERO_REG=1 and rd_addr[i]=0: read returns 0.
  - BYPASS=1, wr_en=1 and wr_addr==rd_addr[i] (nonzero when ZERO_REG=1): read returns wr_data in the same cycle.
  - All ports are independent; duplicate addresses across ports are legal.
- Scoreboard, evaluated per register r on each rising edge, first matching rule wins:
  1. flush=1: busy[r] <= 0 for all r. Takes precedence over iss_en and wr_en.
  2. iss_en=1 and iss_addr==r: busy[r] <= 1. Issue beats a same-cycle writeback to the same register, because the newer instruction owns the result.
  3. wr_en=1 and wr_addr==r: busy[r] <= 0.
  4. Otherwise busy[r] holds.
- Register 0 under ZERO_REG=1 is never set busy.
- A write to a non-busy register is legal: data is stored and busy stays 0.
- rd_busy[i] = busy[rd_addr[i]], with two overrides:
  - Forced to 0 when BYPASS=1, wr_en=1 and wr_addr==rd_addr[i], since the data is forwarded this cycle.
  - Forced to 0 for address 0 when ZERO_REG=1.
- Simultaneous iss_en and wr_en to different registers: both take effect.
- Address width: any address >= DEPTH is impossible because DEPTH is a power of two. No wrap-around logic is required.

Test Plan:
1. Reset with registers holding data: assert rst mid-cycle with reg[5]=0xDEADBEEF and busy[5]=1 -> rd_data for addr 5 is 0 and busy_vec=0 immediately, with no clock edge needed.
2. Write and read-back: write reg[1]=12, then on the next cycle reg[2]=45. Read port0=addr0, port1=addr1 -> 0 and 12. Set port0=addr2 -> 45. Write to addr0 with 0xFFFFFFFF -> addr0 still reads 0.
3. Bypass: in a single cycle, wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5 with port1=addr7 -> rd_data port1 = 0xA5A5A5A5 in that same cycle, before the edge. Repeat with BYPASS=0 -> old value returned until after the edge.
4. Scoreboard RAW: issue addr 3 -> next cycle busy_vec[3]=1 and rd_busy=1 for a port reading 3. Write addr 3 -> rd_busy drops in that cycle (bypass) and busy_vec[3]=0 after the edge.
5. Collisions: in the same cycle iss_en=1 for addr 4 and wr_en=1 for addr 4 (4 already busy) -> busy_vec[4] stays 1 and reg[4] is updated. Issue addr 0 with ZERO_REG=1 -> busy_vec[0] stays 0.
6. Flush: set busy for addrs 2, 9 and 31, then flush=1 with iss_en=1 for addr 6 -> busy_vec=0 after the edge and register contents unchanged. Also run NUM_RD=4, DATA_W=64 with all ports reading distinct registers -> correct per-port data.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port register file with same-cycle write bypass and a
// pending-write scoreboard used by issue logic to detect RAW hazards.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*$clog2(DEPTH)-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0]     rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         wr_en,
    input  logic [$clog2(DEPTH)-1:0]     wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         iss_en,
    input  logic [$clog2(DEPTH)-1:0]     iss_addr,
    input  logic                         flush,
    output logic [DEPTH-1:0]             busy_vec
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam bit          ZR_EN  = (ZERO_REG != 0);
    localparam bit          BYP_EN = (BYPASS != 0);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              wr_keep;

    // Writes to the hardwired zero register are dropped
    assign wr_keep = wr_en && !(ZR_EN && (wr_addr == AW'(0)));

    // Register storage: one write per rising edge, async clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_keep) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Scoreboard next state: flush beats issue, issue beats writeback
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wr_en) begin
                busy_d[wr_addr] = 1'b0;
            end
            if (iss_en) begin
                busy_d[iss_addr] = 1'b1;
            end
        end
        if (ZR_EN) begin
            busy_d[0] = 1'b0;
        end
    end

    // Scoreboard state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    // Per-port combinational read with zero-register and bypass overrides
    for (genvar g = 0; g < int'(NUM_RD); g++) begin : g_rd
        logic [AW-1:0] addr;
        logic          is_zero;
        logic          fwd;

        assign addr    = rd_addr[g*AW +: AW];
        assign is_zero = ZR_EN && (addr == AW'(0));
        assign fwd     = BYP_EN && wr_en && (wr_addr == addr);

        assign rd_data[g*DATA_W +: DATA_W] = is_zero ? '0 :
                                             fwd     ? wr_data : mem_q[addr];
        assign rd_busy[g] = !is_zero && !fwd && busy_q[addr];
    end

endmodule
